// File: rtl/debug_dump_sequencer_pkg.sv
// Shared constants and types for the debug dump sequencer.
// The sequencer streams a header byte, a register/pipeline snapshot and a data-memory image over the UART.
package debug_dump_sequencer_pkg;

  localparam int unsigned TX_BYTE_BITS  = 8;
  localparam int unsigned DEF_PROC_BITS = 32;
  localparam int unsigned DEF_SNAP_LEN  = 1024;
  localparam int unsigned DEF_ADDR_BITS = 10;
  localparam int unsigned DEF_MEM_WORDS = 32;

  localparam logic [TX_BYTE_BITS-1:0] DUMP_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_HDR  = 3'd1,
    SEND_SNAP = 3'd2,
    MEM_REQ   = 3'd3,
    MEM_WAIT  = 3'd4,
    SEND_MEM  = 3'd5,
    WAIT_TX   = 3'd6,
    DONE      = 3'd7
  } dump_state_e;

  // Number of whole bytes in a field of the given width.
  function automatic int unsigned bytes_in(input int unsigned bits, input int unsigned byte_bits);
    return bits / byte_bits;
  endfunction

endpackage

// File: rtl/debug_dump_sequencer_if.sv
// Debug FSM, UART tx and data-memory debug-port signals of the dump sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface debug_dump_sequencer_if
  import debug_dump_sequencer_pkg::*;
#(
  parameter int unsigned UART_BITS       = TX_BYTE_BITS,
  parameter int unsigned SNAP_LEN        = DEF_SNAP_LEN,
  parameter int unsigned PROC_BITS       = DEF_PROC_BITS,
  parameter int unsigned DATA_ADDRS_BITS = DEF_ADDR_BITS
);

  logic                       i_start;
  logic [SNAP_LEN-1:0]        i_snapshot;
  logic [PROC_BITS-1:0]       i_mem_data;
  logic                       i_tx_done;
  logic                       o_tx_start;
  logic [UART_BITS-1:0]       o_tx_data;
  logic                       o_mem_read;
  logic [DATA_ADDRS_BITS-1:0] o_mem_addr;
  logic                       o_busy;
  logic                       o_done;

  modport master (
    output i_start, i_snapshot, i_mem_data, i_tx_done,
    input  o_tx_start, o_tx_data, o_mem_read, o_mem_addr, o_busy, o_done
  );

  modport slave (
    input  i_start, i_snapshot, i_mem_data, i_tx_done,
    output o_tx_start, o_tx_data, o_mem_read, o_mem_addr, o_busy, o_done
  );

endinterface

// File: rtl/debug_dump_sequencer_byte_shifter.sv
// Parallel-load shift register that presents its most significant byte and shifts it out on advance.
// load together with advance loads the word with its top byte already consumed.
module debug_dump_sequencer_byte_shifter
  import debug_dump_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_PROC_BITS,
  parameter int unsigned BYTE_BITS = TX_BYTE_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 advance,
  input  logic [WIDTH-1:0]     din,
  output logic [BYTE_BITS-1:0] head_byte,
  output logic                 empty
);

  localparam int unsigned NBYTES = bytes_in(WIDTH, BYTE_BITS);
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

  logic [WIDTH-1:0] sreg_q;
  logic [CNT_W-1:0] cnt_q;

  // cnt_q counts bytes not yet handed out; zero means the field is exhausted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      if (advance) begin
        sreg_q <= din << BYTE_BITS;
        cnt_q  <= CNT_W'(NBYTES - 1);
      end else begin
        sreg_q <= din;
        cnt_q  <= CNT_W'(NBYTES);
      end
    end else if (advance && (cnt_q != '0)) begin
      sreg_q <= sreg_q << BYTE_BITS;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  assign head_byte = sreg_q[WIDTH-1 -: BYTE_BITS];
  assign empty     = (cnt_q == '0);

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams a debug dump (header, snapshot, data memory image) through the shared UART transmitter.
// All outputs are registered; each SEND_* state is the single cycle in which o_tx_start is high.
module debug_dump_sequencer
  import debug_dump_sequencer_pkg::*;
#(
  parameter int unsigned          UART_BITS       = TX_BYTE_BITS,
  parameter int unsigned          PROC_BITS       = DEF_PROC_BITS,
  parameter int unsigned          SNAP_LEN        = DEF_SNAP_LEN,
  parameter int unsigned          DATA_ADDRS_BITS = DEF_ADDR_BITS,
  parameter int unsigned          MEM_WORDS       = DEF_MEM_WORDS,
  parameter logic [UART_BITS-1:0] HEADER          = UART_BITS'(DUMP_HEADER)
) (
  input  logic                   clk,
  input  logic                   rst,
  debug_dump_sequencer_if.slave  bus
);

  // One extra bit so that MEM_WORDS == 2**DATA_ADDRS_BITS is reachable without wrapping.
  localparam int unsigned ADDR_CNT_W = DATA_ADDRS_BITS + 1;

  dump_state_e state_q, state_d;
  dump_state_e ret_q, ret_d;

  logic [ADDR_CNT_W-1:0]      addr_q, addr_d;
  logic                       tx_start_q, tx_start_d;
  logic [UART_BITS-1:0]       tx_data_q, tx_data_d;
  logic                       mem_read_q, mem_read_d;
  logic [DATA_ADDRS_BITS-1:0] mem_addr_q, mem_addr_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                 snap_load, snap_adv, snap_empty;
  logic                 word_load, word_adv, word_empty;
  logic [UART_BITS-1:0] snap_byte, word_byte;
  logic                 issue_read;

  debug_dump_sequencer_byte_shifter #(
    .WIDTH     (SNAP_LEN),
    .BYTE_BITS (UART_BITS)
  ) u_snap_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (snap_load),
    .advance   (snap_adv),
    .din       (bus.i_snapshot),
    .head_byte (snap_byte),
    .empty     (snap_empty)
  );

  debug_dump_sequencer_byte_shifter #(
    .WIDTH     (PROC_BITS),
    .BYTE_BITS (UART_BITS)
  ) u_word_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (word_load),
    .advance   (word_adv),
    .din       (bus.i_mem_data),
    .head_byte (word_byte),
    .empty     (word_empty)
  );

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    addr_d     = addr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    mem_read_d = 1'b0;
    mem_addr_d = mem_addr_q;
    done_d     = 1'b0;
    snap_load  = 1'b0;
    snap_adv   = 1'b0;
    word_load  = 1'b0;
    word_adv   = 1'b0;
    issue_read = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d    = SEND_HDR;
          snap_load  = 1'b1;
          addr_d     = '0;
          tx_start_d = 1'b1;
          tx_data_d  = HEADER;
        end
      end
      SEND_HDR, SEND_SNAP, SEND_MEM: begin
        ret_d   = state_q;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.i_tx_done) begin
          if (ret_q == SEND_MEM) begin
            if (!word_empty) begin
              state_d    = SEND_MEM;
              tx_start_d = 1'b1;
              tx_data_d  = word_byte;
              word_adv   = 1'b1;
            end else if (addr_q == ADDR_CNT_W'(MEM_WORDS)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              issue_read = 1'b1;
            end
          end else if ((ret_q == SEND_SNAP) && snap_empty) begin
            issue_read = 1'b1;
          end else begin
            state_d    = SEND_SNAP;
            tx_start_d = 1'b1;
            tx_data_d  = snap_byte;
            snap_adv   = 1'b1;
          end
        end
      end
      MEM_REQ: begin
        state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        // Read data is valid now: latch the word and send its top byte straight away.
        state_d    = SEND_MEM;
        word_load  = 1'b1;
        word_adv   = 1'b1;
        tx_start_d = 1'b1;
        tx_data_d  = bus.i_mem_data[PROC_BITS-1 -: UART_BITS];
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue_read) begin
      state_d    = MEM_REQ;
      mem_read_d = 1'b1;
      mem_addr_d = addr_q[DATA_ADDRS_BITS-1:0];
      addr_d     = addr_q + ADDR_CNT_W'(1);
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      addr_q     <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      addr_q     <= addr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_mem_read = mem_read_q;
  assign bus.o_mem_addr = mem_addr_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer: two configurations (2-word and full 4-word address space),
// with a UART model acknowledging 3 cycles after each tx_start and a memory returning data 1 cycle after a read.
module tb_debug_dump_sequencer;
  import debug_dump_sequencer_pkg::*;

  localparam int unsigned SNAP = 16;
  localparam int unsigned PW   = 32;
  localparam int unsigned AW_A = 10;
  localparam int unsigned MW_A = 2;
  localparam int unsigned AW_B = 2;
  localparam int unsigned MW_B = 4;

  typedef logic [7:0] byte_q_t[$];
  typedef int         int_q_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debug_dump_sequencer_if #(.UART_BITS(8), .SNAP_LEN(SNAP), .PROC_BITS(PW), .DATA_ADDRS_BITS(AW_A)) bus_a ();
  debug_dump_sequencer_if #(.UART_BITS(8), .SNAP_LEN(SNAP), .PROC_BITS(PW), .DATA_ADDRS_BITS(AW_B)) bus_b ();

  debug_dump_sequencer #(
    .UART_BITS(8), .PROC_BITS(PW), .SNAP_LEN(SNAP), .DATA_ADDRS_BITS(AW_A), .MEM_WORDS(MW_A), .HEADER(8'hA5)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  debug_dump_sequencer #(
    .UART_BITS(8), .PROC_BITS(PW), .SNAP_LEN(SNAP), .DATA_ADDRS_BITS(AW_B), .MEM_WORDS(MW_B), .HEADER(8'hA5)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int checks;
  int errors;

  byte_q_t     cap_a, cap_b;
  int_q_t      addr_a, addr_b;
  logic [7:0]  last_a, last_b;
  int          cnt_a, cnt_b;
  int          done_a, done_b;
  int          hold_err;
  bit          rd_pend_a, rd_pend_b;
  logic [1:0]  rd_addr_a, rd_addr_b;
  logic [31:0] mem_a [4];
  logic [31:0] mem_b [4];
  bit          inj_st, inj_mw;

  localparam logic [255:0] EXP_A = 256'hA5_BEEF_01020304_CAFEF00D;
  localparam logic [255:0] EXP_B = 256'hA5_1234_A0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack_bytes(input byte_q_t q);
    logic [255:0] v = '0;
    foreach (q[i]) v = {v[247:0], q[i]};
    return v;
  endfunction

  function automatic logic [255:0] pack_addrs(input int_q_t q);
    logic [255:0] v = '0;
    foreach (q[i]) v = {v[251:0], 4'(q[i])};
    return v;
  endfunction

  function automatic logic [21:0] outs_a();
    return {bus_a.o_tx_start, bus_a.o_tx_data, bus_a.o_mem_read, bus_a.o_mem_addr, bus_a.o_busy, bus_a.o_done};
  endfunction

  function automatic logic [13:0] outs_b();
    return {bus_b.o_tx_start, bus_b.o_tx_data, bus_b.o_mem_read, bus_b.o_mem_addr, bus_b.o_busy, bus_b.o_done};
  endfunction

  // One clock: sample just after the edge, then update the UART and memory models.
  task automatic tick();
    @(posedge clk);
    #1;
    bus_a.i_tx_done = 1'b0;
    if (cnt_a != 0) begin
      if (bus_a.o_tx_data !== last_a) hold_err++;
      cnt_a--;
      if (cnt_a == 0) bus_a.i_tx_done = 1'b1;
    end
    if (bus_a.o_tx_start === 1'b1) begin
      cap_a.push_back(bus_a.o_tx_data);
      last_a = bus_a.o_tx_data;
      cnt_a  = 3;
      if (inj_st) bus_a.i_tx_done = 1'b1;
    end
    if (inj_mw && rd_pend_a) bus_a.i_tx_done = 1'b1;
    bus_a.i_mem_data = rd_pend_a ? mem_a[rd_addr_a] : 32'hDEAD_BEEF;
    rd_pend_a = (bus_a.o_mem_read === 1'b1);
    rd_addr_a = bus_a.o_mem_addr[1:0];
    if (bus_a.o_mem_read === 1'b1) addr_a.push_back(int'(bus_a.o_mem_addr));
    if (bus_a.o_done === 1'b1) done_a++;

    bus_b.i_tx_done = 1'b0;
    if (cnt_b != 0) begin
      if (bus_b.o_tx_data !== last_b) hold_err++;
      cnt_b--;
      if (cnt_b == 0) bus_b.i_tx_done = 1'b1;
    end
    if (bus_b.o_tx_start === 1'b1) begin
      cap_b.push_back(bus_b.o_tx_data);
      last_b = bus_b.o_tx_data;
      cnt_b  = 3;
    end
    bus_b.i_mem_data = rd_pend_b ? mem_b[rd_addr_b] : 32'hDEAD_BEEF;
    rd_pend_b = (bus_b.o_mem_read === 1'b1);
    rd_addr_b = bus_b.o_mem_addr;
    if (bus_b.o_mem_read === 1'b1) addr_b.push_back(int'(bus_b.o_mem_addr));
    if (bus_b.o_done === 1'b1) done_b++;
  endtask

  task automatic wait_done(input bit sel_b, input int budget);
    int n;
    n = 0;
    while (((sel_b ? bus_b.o_done : bus_a.o_done) !== 1'b1) && (n < budget)) begin
      tick();
      n++;
    end
    chk(sel_b ? "b_done_within_budget" : "a_done_within_budget",
        256'(sel_b ? bus_b.o_done : bus_a.o_done), 256'(1));
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; hold_err = 0;
    cnt_a = 0; cnt_b = 0; done_a = 0; done_b = 0;
    rd_pend_a = 1'b0; rd_pend_b = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    last_a = '0; last_b = '0; inj_st = 1'b0; inj_mw = 1'b0;
    mem_a = '{32'h01020304, 32'hCAFEF00D, 32'h0, 32'h0};
    mem_b = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
    bus_a.i_start = 1'b0; bus_a.i_snapshot = '0; bus_a.i_mem_data = '0; bus_a.i_tx_done = 1'b0;
    bus_b.i_start = 1'b0; bus_b.i_snapshot = '0; bus_b.i_mem_data = '0; bus_b.i_tx_done = 1'b0;
    rst = 1'b0;

    repeat (3) tick();
    chk("reset_outputs_a", 256'(outs_a()), 256'(0));
    chk("reset_outputs_b", 256'(outs_b()), 256'(0));
    rst = 1'b1;
    repeat (2) tick();
    chk("idle_outputs_a", 256'(outs_a()), 256'(0));

    // Clean dump; header must appear the cycle after the start edge.
    bus_a.i_snapshot = 16'hBEEF;
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    chk("start_busy_tx_hdr", 256'({bus_a.o_busy, bus_a.o_tx_start, bus_a.o_tx_data}), 256'({1'b1, 1'b1, 8'hA5}));
    wait_done(1'b0, 200);
    chk("done_cycle_busy_low", 256'(bus_a.o_busy), 256'(0));
    tick();
    chk("done_single_cycle", 256'(bus_a.o_done), 256'(0));
    chk("run1_stream", pack_bytes(cap_a), EXP_A);
    chk("run1_tx_start_count", 256'(cap_a.size()), 256'(11));
    chk("run1_done_count", 256'(done_a), 256'(1));
    chk("run1_addresses", pack_addrs(addr_a), 256'h01);

    // Spurious tx_done while idle.
    cap_a.delete();
    bus_a.i_tx_done = 1'b1;
    repeat (4) tick();
    chk("idle_spurious_done_busy", 256'(bus_a.o_busy), 256'(0));
    chk("idle_spurious_done_no_byte", 256'(cap_a.size()), 256'(0));

    // Snapshot change, restart, spurious dones; none may alter the frame.
    inj_st = 1'b1; inj_mw = 1'b1; done_a = 0; addr_a.delete();
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    repeat (10) tick();
    bus_a.i_snapshot = 16'h0000;
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    wait_done(1'b0, 200);
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    chk("start_in_done_ignored", 256'(bus_a.o_busy), 256'(0));
    repeat (6) tick();
    chk("run2_stream", pack_bytes(cap_a), EXP_A);
    chk("run2_tx_start_count", 256'(cap_a.size()), 256'(11));
    chk("run2_done_count", 256'(done_a), 256'(1));
    chk("run2_addresses", pack_addrs(addr_a), 256'h01);
    inj_st = 1'b0; inj_mw = 1'b0;

    // Reset during the 4th byte abandons the frame.
    bus_a.i_snapshot = 16'hBEEF;
    cap_a.delete(); done_a = 0;
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    n = 0;
    while ((cap_a.size() < 4) && (n < 100)) begin
      tick();
      n++;
    end
    chk("fourth_byte_reached", 256'(cap_a.size()), 256'(4));
    tick();
    rst = 1'b0;
    cnt_a = 0; rd_pend_a = 1'b0; bus_a.i_tx_done = 1'b0;
    #1;
    chk("async_reset_outputs", 256'(outs_a()), 256'(0));
    tick();
    chk("reset_next_cycle_outputs", 256'(outs_a()), 256'(0));
    rst = 1'b1;
    repeat (3) tick();
    chk("no_done_after_reset", 256'(done_a), 256'(0));
    chk("no_bytes_after_reset", 256'(cap_a.size()), 256'(4));
    cap_a.delete();
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    wait_done(1'b0, 200);
    chk("post_reset_stream", pack_bytes(cap_a), EXP_A);
    chk("post_reset_done_count", 256'(done_a), 256'(1));

    // Full address space on the 2-bit configuration.
    bus_b.i_snapshot = 16'h1234;
    bus_b.i_start = 1'b1;
    tick();
    bus_b.i_start = 1'b0;
    wait_done(1'b1, 300);
    tick();
    chk("b_stream", pack_bytes(cap_b), EXP_B);
    chk("b_addresses", pack_addrs(addr_b), 256'h0123);
    chk("b_done_count", 256'(done_b), 256'(1));
    chk("b_addr_held_read_low", 256'({bus_b.o_mem_read, bus_b.o_mem_addr}), 256'({1'b0, 2'd3}));
    bus_b.i_start = 1'b1;
    tick();
    bus_b.i_start = 1'b0;
    chk("b_restart_after_done", 256'({bus_b.o_busy, bus_b.o_tx_start, bus_b.o_tx_data}), 256'({1'b1, 1'b1, 8'hA5}));
    wait_done(1'b1, 300);
    chk("b_second_frame_bytes", 256'(cap_b.size()), 256'(38));
    chk("tx_data_held_until_done", 256'(hold_err), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
